// File: rtl/digit_box_sched_pkg.sv
// Shared constants for the digit bounding-box scheduler and the LCD frame blocks.
package digit_box_sched_pkg;

    // LCD active frame geometry
    localparam int unsigned LCD_H_ACT = 480;
    localparam int unsigned LCD_V_ACT = 272;

    // Coordinate width and the tracker "nothing seen" sentinel
    localparam int unsigned BOX_CW = 9;
    localparam logic [BOX_CW-1:0] BOX_SENTINEL = '1;

    // Scheduler FSM states
    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_SCAN  = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [ST_W-1:0] ST_LATCH = 3'd3;
    localparam logic [ST_W-1:0] ST_HOLD  = 3'd4;

endpackage

// File: rtl/digit_box_pixcnt.sv
// Raster x/y counter over the active frame with a last-pixel flag.
module digit_box_pixcnt
    import digit_box_sched_pkg::*;
#(
    parameter int unsigned H_ACT = LCD_H_ACT,
    parameter int unsigned V_ACT = LCD_V_ACT,
    parameter int unsigned CW    = BOX_CW
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          last_c
);

    logic x_end_c;
    logic y_end_c;

    assign x_end_c = (x == CW'(H_ACT - 1));
    assign y_end_c = (y == CW'(V_ACT - 1));
    assign last_c  = x_end_c & y_end_c;

    // Advance x per pixel, wrap at line end and step y; clear restarts the frame
    always_ff @(posedge clock) begin
        if (rst || clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x_end_c) begin
                x <= '0;
                y <= y_end_c ? '0 : y + CW'(1);
            end else begin
                x <= x + CW'(1);
            end
        end
    end

endmodule

// File: rtl/digit_box_sched.sv
// Frame scheduler: drives the extremum trackers during the scan, then
// captures the resulting bounding box and offers it downstream.
module digit_box_sched
    import digit_box_sched_pkg::*;
#(
    parameter int unsigned H_ACT  = LCD_H_ACT,
    parameter int unsigned V_ACT  = LCD_V_ACT,
    parameter int unsigned CW     = BOX_CW,
    parameter int unsigned SETTLE = 3
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          pixel_valid,
    input  logic          pixel_fg,
    output logic          trk_wren,
    output logic [CW-1:0] trk_x,
    output logic [CW-1:0] trk_y,
    output logic          trk_clr,
    input  logic [CW-1:0] min_x_in,
    input  logic [CW-1:0] max_x_in,
    input  logic [CW-1:0] min_y_in,
    input  logic [CW-1:0] max_y_in,
    output logic [CW-1:0] box_min_x,
    output logic [CW-1:0] box_max_x,
    output logic [CW-1:0] box_min_y,
    output logic [CW-1:0] box_max_y,
    output logic          box_empty,
    output logic          box_valid,
    input  logic          box_ready,
    output logic          err_short,
    output logic [7:0]    drop_cnt
);

    localparam int unsigned SW = $clog2(SETTLE + 2);
    localparam logic [CW-1:0] SENTINEL = '1;

    logic [ST_W-1:0] state, state_nxt;
    logic [SW-1:0]   settle, settle_nxt;

    logic          cnt_clr_c;
    logic          cnt_adv_c;
    logic [CW-1:0] cnt_x;
    logic [CW-1:0] cnt_y;
    logic          cnt_last_c;

    logic          trk_wren_nxt;
    logic [CW-1:0] trk_x_nxt;
    logic [CW-1:0] trk_y_nxt;
    logic          trk_clr_nxt;
    logic [CW-1:0] box_min_x_nxt;
    logic [CW-1:0] box_max_x_nxt;
    logic [CW-1:0] box_min_y_nxt;
    logic [CW-1:0] box_max_y_nxt;
    logic          box_empty_nxt;
    logic          box_valid_nxt;
    logic          err_short_nxt;
    logic [7:0]    drop_cnt_nxt;

    digit_box_pixcnt #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .CW    (CW)
    ) u_pixcnt (
        .clock  (clock),
        .rst    (rst),
        .clr    (cnt_clr_c),
        .adv    (cnt_adv_c),
        .x      (cnt_x),
        .y      (cnt_y),
        .last_c (cnt_last_c)
    );

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= ST_IDLE;
            settle    <= '0;
            trk_wren  <= 1'b0;
            trk_x     <= '0;
            trk_y     <= '0;
            trk_clr   <= 1'b0;
            box_min_x <= '0;
            box_max_x <= '0;
            box_min_y <= '0;
            box_max_y <= '0;
            box_empty <= 1'b0;
            box_valid <= 1'b0;
            err_short <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            settle    <= settle_nxt;
            trk_wren  <= trk_wren_nxt;
            trk_x     <= trk_x_nxt;
            trk_y     <= trk_y_nxt;
            trk_clr   <= trk_clr_nxt;
            box_min_x <= box_min_x_nxt;
            box_max_x <= box_max_x_nxt;
            box_min_y <= box_min_y_nxt;
            box_max_y <= box_max_y_nxt;
            box_empty <= box_empty_nxt;
            box_valid <= box_valid_nxt;
            err_short <= err_short_nxt;
            drop_cnt  <= drop_cnt_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt     = state;
        settle_nxt    = settle;
        cnt_clr_c     = 1'b0;
        cnt_adv_c     = 1'b0;
        trk_wren_nxt  = 1'b0;
        trk_x_nxt     = trk_x;
        trk_y_nxt     = trk_y;
        trk_clr_nxt   = 1'b0;
        box_min_x_nxt = box_min_x;
        box_max_x_nxt = box_max_x;
        box_min_y_nxt = box_min_y;
        box_max_y_nxt = box_max_y;
        box_empty_nxt = box_empty;
        box_valid_nxt = box_valid;
        err_short_nxt = 1'b0;
        drop_cnt_nxt  = drop_cnt;

        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nxt = ST_SCAN;
                    cnt_clr_c = 1'b1;
                end
            end
            ST_SCAN: begin
                if (frame_start) begin
                    // Restart: the coincident pixel is discarded
                    err_short_nxt = 1'b1;
                    trk_clr_nxt   = 1'b1;
                    cnt_clr_c     = 1'b1;
                end else if (pixel_valid) begin
                    trk_x_nxt    = cnt_x;
                    trk_y_nxt    = cnt_y;
                    trk_wren_nxt = pixel_fg;
                    cnt_adv_c    = 1'b1;
                    if (cnt_last_c) begin
                        state_nxt  = ST_WAIT;
                        settle_nxt = SW'(SETTLE);
                    end
                end
            end
            ST_WAIT: begin
                settle_nxt = settle - SW'(1);
                if (settle <= SW'(1)) begin
                    // Clear is seen by the trackers at the end of LATCH
                    state_nxt   = ST_LATCH;
                    trk_clr_nxt = 1'b1;
                end
            end
            ST_LATCH: begin
                box_min_x_nxt = min_x_in;
                box_max_x_nxt = max_x_in;
                box_min_y_nxt = min_y_in;
                box_max_y_nxt = max_y_in;
                box_empty_nxt = (min_x_in == SENTINEL);
                box_valid_nxt = 1'b1;
                state_nxt     = ST_HOLD;
            end
            ST_HOLD: begin
                if (box_ready) begin
                    box_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Frames arriving while the previous box is still in flight are dropped
        if (frame_start && (state == ST_WAIT || state == ST_LATCH || state == ST_HOLD)
            && (drop_cnt != 8'hFF)) begin
            drop_cnt_nxt = drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_digit_box_sched.sv
// Directed bench for digit_box_sched on an 8x4 frame with a behavioural tracker.
module tb_digit_box_sched;
    import digit_box_sched_pkg::*;

    localparam int unsigned H = 8;
    localparam int unsigned V = 4;
    localparam int unsigned W = 9;

    typedef struct packed {
        logic [W-1:0] mnx;
        logic [W-1:0] mxx;
        logic [W-1:0] mny;
        logic [W-1:0] mxy;
        logic         empty;
    } exp_t;

    logic         clock = 1'b0;
    logic         rst = 1'b1;
    logic         frame_start = 1'b0;
    logic         pixel_valid = 1'b0;
    logic         pixel_fg = 1'b0;
    logic         box_ready = 1'b0;
    logic         trk_wren;
    logic [W-1:0] trk_x;
    logic [W-1:0] trk_y;
    logic         trk_clr;
    logic [W-1:0] min_x_in, max_x_in, min_y_in, max_y_in;
    logic [W-1:0] box_min_x, box_max_x, box_min_y, box_max_y;
    logic         box_empty;
    logic         box_valid;
    logic         err_short;
    logic [7:0]   drop_cnt;

    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    digit_box_sched #(
        .H_ACT  (H),
        .V_ACT  (V),
        .CW     (W),
        .SETTLE (3)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .pixel_fg    (pixel_fg),
        .trk_wren    (trk_wren),
        .trk_x       (trk_x),
        .trk_y       (trk_y),
        .trk_clr     (trk_clr),
        .min_x_in    (min_x_in),
        .max_x_in    (max_x_in),
        .min_y_in    (min_y_in),
        .max_y_in    (max_y_in),
        .box_min_x   (box_min_x),
        .box_max_x   (box_max_x),
        .box_min_y   (box_min_y),
        .box_max_y   (box_max_y),
        .box_empty   (box_empty),
        .box_valid   (box_valid),
        .box_ready   (box_ready),
        .err_short   (err_short),
        .drop_cnt    (drop_cnt)
    );

    always #5 clock = ~clock;

    // Extremum tracker model: one-cycle update, sentinel min / zero max when cleared
    always @(posedge clock) begin
        if (rst || trk_clr) begin
            min_x_in <= '1;
            max_x_in <= '0;
            min_y_in <= '1;
            max_y_in <= '0;
        end else if (trk_wren) begin
            if (trk_x < min_x_in) min_x_in <= trk_x;
            if (trk_x > max_x_in) max_x_in <= trk_x;
            if (trk_y < min_y_in) min_y_in <= trk_y;
            if (trk_y > max_y_in) max_y_in <= trk_y;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_box(input logic [31:0] m);
        exp_t r;
        r.mnx = '1; r.mxx = '0; r.mny = '1; r.mxy = '0; r.empty = 1'b1;
        for (int p = 0; p < 32; p++) begin
            if (m[p]) begin
                if (W'(p % 8) < r.mnx) r.mnx = W'(p % 8);
                if (W'(p % 8) > r.mxx) r.mxx = W'(p % 8);
                if (W'(p / 8) < r.mny) r.mny = W'(p / 8);
                if (W'(p / 8) > r.mxy) r.mxy = W'(p / 8);
                r.empty = 1'b0;
            end
        end
        return r;
    endfunction

    // Scoreboard: compare the box at every accepted handshake
    always @(negedge clock) begin
        if (!rst && box_valid === 1'b1 && box_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_box", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_box", 64'({box_min_x, box_max_x, box_min_y, box_max_y, box_empty}), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Drive n pixels of mask from the frame origin and check the tracker strobes
    task automatic run_pixels(input logic [31:0] m, input int n, output int wren_cnt);
        wren_cnt = 0;
        for (int p = 0; p < n; p++) begin
            pixel_valid = 1'b1;
            pixel_fg    = m[p];
            tick();
            check("trk_wren", 64'(trk_wren), 64'(m[p]));
            if (trk_wren === 1'b1) begin
                wren_cnt++;
                check("trk_xy", 64'({trk_x, trk_y}), 64'({W'(p % 8), W'(p / 8)}));
            end
        end
        pixel_valid = 1'b0;
        pixel_fg    = 1'b0;
    endtask

    task automatic wait_box();
        int n = 0;
        while (box_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("box_valid_timeout", 64'(box_valid), 64'(1));
    endtask

    task automatic handshake();
        box_ready = 1'b1;
        tick();
        box_ready = 1'b0;
        check("box_valid_drop", 64'(box_valid), 64'(0));
        check("state_idle", 64'(dut.state), 64'(ST_IDLE));
    endtask

    task automatic full_frame(input logic [31:0] m);
        int wc;
        start_frame();
        run_pixels(m, 32, wc);
        sb_q.push_back(model_box(m));
        wait_box();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   wc;
        exp_t e;

        // Reset values
        repeat (3) tick();
        check("rst_outs", 64'({trk_wren, trk_clr, box_valid, box_empty, err_short}), 64'(0));
        check("rst_box", 64'({box_min_x, box_max_x, box_min_y, box_max_y}), 64'(0));
        check("rst_drop", 64'(drop_cnt), 64'(0));
        check("rst_state", 64'(dut.state), 64'(ST_IDLE));
        rst = 1'b0;
        tick();

        // 1: two foreground pixels, settle timing and clear pulse
        start_frame();
        run_pixels(32'h2000_0400, 32, wc);
        check("s1_wren_count", 64'(wc), 64'(2));
        sb_q.push_back(model_box(32'h2000_0400));
        tick(); tick();
        check("s1_wait_clr", 64'({trk_clr, box_valid, trk_wren}), 64'(0));
        tick();
        check("s1_latch_clr", 64'({trk_clr, box_valid}), 64'(2'b10));
        tick();
        check("s1_hold", 64'({trk_clr, box_valid, box_empty}), 64'(3'b010));
        check("s1_box", 64'({box_min_x, box_max_x, box_min_y, box_max_y}),
              64'({W'(2), W'(5), W'(1), W'(3)}));
        handshake();

        // 2: empty frame
        full_frame(32'h0);
        check("s2_empty", 64'({box_empty, box_valid}), 64'(2'b11));
        check("s2_min_x", 64'(box_min_x), 64'(9'h1FF));
        handshake();

        // 3: back-pressure for 10 cycles
        full_frame(32'h8000_0001);
        e = model_box(32'h8000_0001);
        for (int i = 0; i < 10; i++) begin
            check("s3_hold_valid", 64'(box_valid), 64'(1));
            check("s3_hold_box", 64'({box_min_x, box_max_x, box_min_y, box_max_y, box_empty}), 64'(e));
            tick();
        end
        handshake();

        // 4: restart after 13 pixels; coincident pixel ignored
        start_frame();
        run_pixels(32'h0000_0008, 13, wc);
        frame_start = 1'b1; pixel_valid = 1'b1; pixel_fg = 1'b1;
        tick();
        frame_start = 1'b0; pixel_valid = 1'b0; pixel_fg = 1'b0;
        check("s4_abort", 64'({err_short, trk_clr, trk_wren}), 64'(3'b110));
        tick();
        check("s4_pulse_end", 64'({err_short, trk_clr}), 64'(0));
        run_pixels(32'h0040_1000, 32, wc);
        sb_q.push_back(model_box(32'h0040_1000));
        wait_box();
        check("s4_box", 64'({box_min_x, box_max_x, box_min_y, box_max_y}),
              64'({W'(4), W'(6), W'(1), W'(2)}));
        handshake();

        // 5: frame_starts while holding; second one coincides with acceptance
        full_frame(32'h0000_0200);
        frame_start = 1'b1; pixel_valid = 1'b1; pixel_fg = 1'b1;
        tick();
        frame_start = 1'b0; pixel_valid = 1'b0; pixel_fg = 1'b0;
        check("s5_drop1", 64'({drop_cnt, box_valid, trk_wren}), 64'({8'd1, 1'b1, 1'b0}));
        tick();
        frame_start = 1'b1; box_ready = 1'b1;
        tick();
        frame_start = 1'b0; box_ready = 1'b0;
        check("s5_drop2", 64'({drop_cnt, box_valid}), 64'({8'd2, 1'b0}));
        check("s5_idle", 64'(dut.state), 64'(ST_IDLE));
        full_frame(32'h0802_0000);
        handshake();
        check("s5_drop_kept", 64'(drop_cnt), 64'(2));

        // 6: reset during WAIT, then a clean frame
        start_frame();
        run_pixels(32'h0000_4000, 32, wc);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s6_rst", 64'({box_valid, drop_cnt, trk_clr}), 64'(0));
        check("s6_idle", 64'(dut.state), 64'(ST_IDLE));
        repeat (6) tick();
        check("s6_no_box", 64'(box_valid), 64'(0));
        full_frame(32'h0080_0100);
        check("s6_box", 64'({box_min_x, box_max_x, box_min_y, box_max_y}),
              64'({W'(0), W'(7), W'(1), W'(2)}));
        handshake();

        tick();
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
